// File: rtl/axi_burst_master.sv
// Command-driven AXI master: one write (AW/W) or read (AR/R) burst per accepted command.
// Latency: AxVALID rises the cycle after accept; W/R beats are combinational pass-through; done follows the final beat by one cycle.
// Backpressure: cmd_ready only in IDLE; AxVALID held until AxREADY; W/R beats stall on WREADY / rd_ready.
module axi_burst_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [1:0]            cmd_burst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic                  done,
    output logic                  err,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [LEN_WIDTH-1:0]  AWLEN,
    output logic [2:0]            AWSIZE,
    output logic [1:0]            AWBURST,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [LEN_WIDTH-1:0]  ARLEN,
    output logic [2:0]            ARSIZE,
    output logic [1:0]            ARBURST,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY
);

    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);
    // Wide enough for addr[11:0] plus the largest (len+1) << 7 without overflow.
    localparam int SPAN_W   = LEN_WIDTH + 14;

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_AR, S_R, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic [LEN_WIDTH:0]    cnt_q, cnt_d;
    logic                  err_q, err_d;

    logic               in_w, in_r, last_beat, w_xfer, r_xfer;
    logic               cmd_ok, wrap_len_ok, crosses_4k;
    logic [LEN_WIDTH:0] beats;
    logic [SPAN_W-1:0]  end_off;

    // Legality of the command currently presented (evaluated in the accept cycle).
    assign beats       = {1'b0, cmd_len} + {{LEN_WIDTH{1'b0}}, 1'b1};
    assign end_off     = SPAN_W'(cmd_addr[11:0]) + (SPAN_W'(beats) << cmd_size);
    assign crosses_4k  = end_off > SPAN_W'(4096);
    assign wrap_len_ok = (cmd_len == LEN_WIDTH'(1)) || (cmd_len == LEN_WIDTH'(3)) ||
                         (cmd_len == LEN_WIDTH'(7)) || (cmd_len == LEN_WIDTH'(15));
    assign cmd_ok      = (cmd_size <= 3'(MAX_SIZE)) && (cmd_burst != 2'd3) &&
                         !((cmd_burst == 2'd2) && !wrap_len_ok) &&
                         !((cmd_burst == 2'd1) && crosses_4k);

    assign in_w      = (state_q == S_W);
    assign in_r      = (state_q == S_R);
    assign last_beat = (cnt_q == {1'b0, len_q});
    assign w_xfer    = in_w && wr_valid && WREADY;
    assign r_xfer    = in_r && RVALID && rd_ready;

    // Client status.
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = done && err_q;

    // Address channels driven straight from the latched command.
    assign AWADDR  = addr_q;
    assign AWLEN   = len_q;
    assign AWSIZE  = size_q;
    assign AWBURST = burst_q;
    assign AWVALID = (state_q == S_AW);
    assign ARADDR  = addr_q;
    assign ARLEN   = len_q;
    assign ARSIZE  = size_q;
    assign ARBURST = burst_q;
    assign ARVALID = (state_q == S_AR);

    // Beat pass-through; handshake signals are gated to their data phase.
    assign WDATA    = wr_data;
    assign WVALID   = in_w && wr_valid;
    assign wr_ready = in_w && WREADY;
    assign WLAST    = in_w && last_beat;
    assign rd_data  = RDATA;
    assign rd_valid = in_r && RVALID;
    assign RREADY   = in_r && rd_ready;
    assign rd_last  = in_r && last_beat;

    // State and command registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state: accept/reject, address handshakes, beat counting, RLAST check.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    size_d  = cmd_size;
                    burst_d = cmd_burst;
                    cnt_d   = '0;
                    if (!cmd_ok) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = cmd_write ? S_AW : S_AR;
                    end
                end
            end
            S_AW: if (AWREADY) state_d = S_W;
            S_W: begin
                if (w_xfer) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) state_d = S_DONE;
                end
            end
            S_AR: if (ARREADY) state_d = S_R;
            S_R: begin
                if (r_xfer) begin
                    cnt_d = cnt_q + 1'b1;
                    // A slave RLAST that disagrees with our count flags the burst but does not cut it short.
                    if (RLAST != last_beat) err_d = 1'b1;
                    if (last_beat) state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_burst_master.sv
module tb_axi_burst_master;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic [31:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, rd_ready, rd_last;
    logic        done, err, busy;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID, AWREADY;
    logic [31:0] WDATA;
    logic        WLAST, WVALID, WREADY;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID, ARREADY;
    logic [31:0] RDATA;
    logic        RLAST, RVALID, RREADY;

    int n_chk  = 0;
    int n_fail = 0;

    axi_burst_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
        .done(done), .err(err), .busy(busy),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; returns 1 time unit after the rising edge.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Presents a command for one accepted cycle; returns just after the accept edge.
    task automatic issue(input logic wr, input logic [31:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] b);
        cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_size = s; cmd_burst = b;
        cmd_valid = 1'b1;
        #1;
        chk("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        #1;
    endtask

    initial begin
        int beat;
        int cyc;
        logic tog;

        ARESETn = 1'b0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0; cmd_burst = 0;
        wr_data = 0; wr_valid = 0; rd_ready = 0;
        AWREADY = 0; WREADY = 0; ARREADY = 0; RDATA = 0; RLAST = 0; RVALID = 0;
        #2;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        chk("rst_valids", {28'd0, AWVALID, WVALID, ARVALID, RREADY}, 32'd0);
        chk("rst_awaddr", AWADDR, 32'd0);
        #10;
        ARESETn = 1'b1;
        tick();

        // ---- Write INCR 0x10 len 3 size 2, ready slave ----
        AWREADY = 1; WREADY = 1; wr_valid = 1; wr_data = 32'hA0;
        issue(1'b1, 32'h10, 8'd3, 3'd2, 2'd1);
        chk("wr_awvalid", 32'(AWVALID), 32'd1);
        chk("wr_awaddr", AWADDR, 32'h10);
        chk("wr_awfields", {19'd0, AWLEN, AWSIZE, AWBURST}, {19'd0, 8'd3, 3'd2, 2'd1});
        chk("wr_no_w_in_aw", 32'(WVALID), 32'd0);
        chk("wr_busy", 32'(busy), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            wr_data = 32'hA0 + 32'(i);
            #1;
            chk("wr_wvalid", 32'(WVALID), 32'd1);
            chk("wr_wdata", WDATA, 32'hA0 + 32'(i));
            chk("wr_wlast", 32'(WLAST), (i == 3) ? 32'd1 : 32'd0);
            chk("wr_awvalid_low", 32'(AWVALID), 32'd0);
            chk("wr_done_early", 32'(done), 32'd0);
            tick();
        end
        wr_valid = 0;
        #1;
        chk("wr_done", 32'(done), 32'd1);
        chk("wr_err", 32'(err), 32'd0);
        chk("wr_cmd_ready_in_done", 32'(cmd_ready), 32'd0);
        tick();
        chk("wr_done_one_cycle", 32'(done), 32'd0);
        chk("wr_cmd_ready_after", 32'(cmd_ready), 32'd1);

        // ---- Read back with rd_ready toggling ----
        ARREADY = 1;
        issue(1'b0, 32'h10, 8'd3, 3'd2, 2'd1);
        chk("rd_arvalid", 32'(ARVALID), 32'd1);
        chk("rd_araddr", ARADDR, 32'h10);
        chk("rd_awvalid_low", 32'(AWVALID), 32'd0);
        tick();
        beat = 0; cyc = 0; tog = 1'b1;
        RVALID = 1;
        while (beat < 4 && cyc < 20) begin
            rd_ready = tog;
            RDATA = 32'hA0 + 32'(beat);
            RLAST = (beat == 3);
            #1;
            chk("rd_valid", 32'(rd_valid), 32'd1);
            chk("rd_data", rd_data, 32'hA0 + 32'(beat));
            chk("rd_rready", 32'(RREADY), 32'(tog));
            chk("rd_last", 32'(rd_last), (beat == 3) ? 32'd1 : 32'd0);
            tick();
            if (tog) beat++;
            tog = ~tog;
            cyc++;
        end
        chk("rd_beats_within_budget", 32'(beat), 32'd4);
        RVALID = 0; RLAST = 0; rd_ready = 0;
        #1;
        chk("rd_done", 32'(done), 32'd1);
        chk("rd_err", 32'(err), 32'd0);
        tick();

        // ---- AWREADY held low 5 cycles ----
        AWREADY = 0; wr_valid = 1; wr_data = 32'hB0;
        issue(1'b1, 32'h10, 8'd0, 3'd2, 2'd1);
        for (int i = 0; i < 5; i++) begin
            chk("aw_stall_valid", 32'(AWVALID), 32'd1);
            chk("aw_stall_addr", AWADDR, 32'h10);
            chk("aw_stall_no_w", {30'd0, WVALID, wr_ready}, 32'd0);
            tick();
        end
        AWREADY = 1;
        #1;
        chk("aw_stall_valid_at_hs", 32'(AWVALID), 32'd1);
        tick();
        chk("aw_stall_wbeat", {30'd0, WVALID, WLAST}, 32'd3);
        tick();
        wr_valid = 0;
        #1;
        chk("aw_stall_done", {30'd0, done, err}, 32'd2);
        tick();

        // ---- WRAP with len 2: rejected ----
        issue(1'b1, 32'h40, 8'd2, 3'd2, 2'd2);
        chk("wrap_no_axi", {30'd0, AWVALID, ARVALID}, 32'd0);
        chk("wrap_done_err", {30'd0, done, err}, 32'd3);
        tick();
        chk("wrap_done_one_cycle", 32'(done), 32'd0);
        chk("wrap_cmd_ready", 32'(cmd_ready), 32'd1);

        // ---- INCR crossing 4 KB: rejected ----
        issue(1'b0, 32'hFF8, 8'd3, 3'd2, 2'd1);
        chk("cross4k_no_axi", {30'd0, AWVALID, ARVALID}, 32'd0);
        chk("cross4k_done_err", {30'd0, done, err}, 32'd3);
        tick();

        // ---- size above bus width: rejected ----
        issue(1'b1, 32'h0, 8'd0, 3'd3, 2'd1);
        chk("bigsize_done_err", {30'd0, done, err}, 32'd3);
        tick();

        // ---- INCR ending exactly at 4 KB: accepted ----
        AWREADY = 1; WREADY = 1; wr_valid = 1; wr_data = 32'hC0;
        issue(1'b1, 32'hFFC, 8'd0, 3'd2, 2'd1);
        chk("edge4k_awvalid", 32'(AWVALID), 32'd1);
        chk("edge4k_no_done", 32'(done), 32'd0);
        tick();
        tick();
        wr_valid = 0;
        #1;
        chk("edge4k_done", {30'd0, done, err}, 32'd2);
        tick();

        // ---- Read len 3 with early RLAST on beat 2 ----
        ARREADY = 1; rd_ready = 1;
        issue(1'b0, 32'h20, 8'd3, 3'd2, 2'd1);
        tick();
        RVALID = 1;
        for (int i = 0; i < 4; i++) begin
            RDATA = 32'hD0 + 32'(i);
            RLAST = (i == 1);
            #1;
            chk("rlast_bad_rd_last", 32'(rd_last), (i == 3) ? 32'd1 : 32'd0);
            chk("rlast_bad_no_done", 32'(done), 32'd0);
            tick();
        end
        RVALID = 0; RLAST = 0; rd_ready = 0;
        #1;
        chk("rlast_bad_done_err", {30'd0, done, err}, 32'd3);
        tick();

        // ---- Reset during 2nd W beat of a len-7 write ----
        AWREADY = 1; WREADY = 1; wr_valid = 1; wr_data = 32'hE0;
        issue(1'b1, 32'h100, 8'd7, 3'd2, 2'd1);
        tick();
        tick();
        wr_data = 32'hE1;
        #1;
        chk("rst_mid_wvalid_before", 32'(WVALID), 32'd1);
        ARESETn = 1'b0;
        #1;
        chk("rst_mid_valids", {29'd0, WVALID, AWVALID, busy}, 32'd0);
        chk("rst_mid_no_done", 32'(done), 32'd0);
        tick();
        chk("rst_mid_held_no_done", {30'd0, done, WVALID}, 32'd0);
        #3;
        ARESETn = 1'b1;
        tick();
        chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_mid_idle", {30'd0, busy, done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- Command-driven AXI master that issues single write or read bursts on the AW/W and AR/R channels of the team's AXI slave memory (axi_design).
- It is the upstream stage of the slave: a local client posts a burst command plus a write-data stream.
- The block runs the address handshake, sequences beats, generates WLAST, returns read data and checks RLAST.
- The interface has no B channel and no strobes; write completion is declared on the handshake of the final W beat.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, data width (32 or 64); MAX_SIZE = log2(DATA_WIDTH/8).
- LEN_WIDTH, 8, AxLEN width; beats per burst = len+1.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  start address.
- cmd_len  in  LEN_WIDTH  beats-1.
- cmd_size  in  3  bytes per beat = 2^size.
- cmd_burst  in  2  0 FIXED, 1 INCR, 2 WRAP.
- wr_data  in  DATA_WIDTH  write beat data.
- wr_valid  in  1  write beat available.
- wr_ready  out  1  write beat consumed.
- rd_data  out  DATA_WIDTH  read beat data.
- rd_valid  out  1  read beat valid.
- rd_ready  in  1  client accepts read beat.
- rd_last  out  1  final read beat (counter-based).
- done  out  1  one-cycle pulse at burst end or on rejection.
- err  out  1  qualifies done: rejected command or RLAST mismatch.
- busy  out  1  state != IDLE.
- AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out  ADDR_WIDTH/LEN_WIDTH/3/2/1  write address channel.
- AWREADY  in  1
- WDATA/WLAST/WVALID  out  DATA_WIDTH/1/1  write data channel.
- WREADY  in  1
- ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out  ADDR_WIDTH/LEN_WIDTH/3/2/1  read address channel.
- ARREADY  in  1
- RDATA  in  DATA_WIDTH
- RLAST  in  1
- RVALID  in  1
- RREADY  out  1

Behaviour:
- Reset values (asynchronous assert, synchronous release): state IDLE; AWVALID, WVALID, ARVALID, RREADY, done, err, busy = 0; all address/len/size/burst registers = 0; beat counter = 0.
- Registered outputs: cmd_ready = 1 after reset.
- Command accept: on cmd_valid && cmd_ready, latch all cmd_* fields, then run the legality check in the same cycle.
  - size > MAX_SIZE → reject.
  - burst == 3 → reject.
  - WRAP with len not in {1,3,7,15} → reject.
  - INCR where addr[11:0] + ((len+1)<<size) > 4096 → reject.
  - On reject: state goes to DONE, no AXI traffic, err = 1 with done.
- States:
  - IDLE: wait for a command.
  - AW: AWVALID = 1 with registered fields; on AWREADY go to W.
  - W: W beats.
  - AR: ARVALID = 1; on ARREADY go to R.
  - R: R beats.
  - DONE: done = 1 for exactly one cycle, then IDLE.
- AWVALID/ARVALID rise the cycle after accept and stay high, fields stable, until the ready is sampled high; they are never withdrawn.
- W phase (combinational pass-through):
  - WVALID = wr_valid; WDATA = wr_data; wr_ready = WREADY.
  - WLAST = (beat_cnt == len_q).
  - A beat transfers when WVALID && WREADY; beat_cnt increments per transfer.
  - The transfer with WLAST → DONE, err = 0.
- R phase (combinational pass-through):
  - rd_valid = RVALID; rd_data = RDATA; RREADY = rd_ready.
  - rd_last = (beat_cnt == len_q).
  - On transfer with beat_cnt == len_q → DONE.
  - If RLAST != rd_last on any transfer, set sticky err_q. The burst still runs to counter end, and err = err_q with done.
- Outside the W/R states all pass-through valids and readys are forced to 0.
- Counter wraps never occur: len_q is at most 2^LEN_WIDTH-1 and the counter is LEN_WIDTH+1 bits wide.
- Reset mid-burst: immediate return to IDLE with all valids low. The partial burst is abandoned, no done is pulsed, and the slave is also reset.
- No pipelining of commands: the next command is accepted no earlier than the cycle after done.

Test Plan:
- Write INCR addr 0x10, len 3, size 2, data 0xA0..0xA3, AWREADY/WREADY held 1 → AW handshake 1 cycle after accept; 4 W beats on consecutive cycles; WLAST only on 0xA3; done=1 err=0 next cycle.
- Read back the same burst with RREADY gated by rd_ready toggling 1/0 → rd_data 0xA0..0xA3 in order; rd_last on beat 4; RLAST matches; err=0.
- AWREADY held low 5 cycles → AWVALID stays 1 with AWADDR=0x10 stable for all 5; no W beats before the handshake.
- WRAP len 2 (3 beats) → no AWVALID/ARVALID; done=1 err=1 one cycle after accept; cmd_ready back to 1 after that.
- INCR addr 0xFF8, len 3, size 2 (crosses 4 KB) → rejected with err=1. Read len 3 with the slave asserting RLAST on beat 2 → 4 beats consumed, done with err=1.
- ARESETn low during the 2nd W beat of a len-7 write → WVALID, AWVALID and busy drop to 0 asynchronously; no done; cmd_ready=1 after release.
